// File: rtl/rom_loader.sv
// Length-prefixed byte-stream loader that writes 16-bit big-endian words into instruction RAM
// while holding the CPU in reset. Optional trailing checksum: ROM_LOADER_CHECKSUM_EN.
module rom_loader #(
    parameter int DW      = 16,
    parameter int AW      = 15,
    parameter int TIMEOUT = 1_000_000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          rx_valid,
    input  logic [7:0]    rx_data,
    output logic [AW-1:0] ram_addr,
    output logic          ram_write,
    output logic [DW-1:0] ram_wdata,
    output logic          cpu_hold,
    output logic          busy,
    output logic          done,
    output logic          error
);

    typedef enum logic [3:0] {
        IDLE, HDR_HI, HDR_LO, DATA_HI, DATA_LO, CSUM_HI, CSUM_LO, FIN, ERR
    } state_t;

    localparam int              CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0]   TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [16:0]     DEPTH   = 17'd1 << AW;

    state_t          state_q, state_d;
    logic [7:0]      hi_q, hi_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [16:0]     rem_q, rem_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   ram_addr_q, ram_addr_d;
    logic [DW-1:0]   ram_wdata_q, ram_wdata_d;
    logic            ram_write_q, ram_write_d;
    logic            cpu_hold_q, cpu_hold_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            error_q, error_d;
    logic [16:0]     n_hdr;
    logic            in_frame;
`ifdef ROM_LOADER_CHECKSUM_EN
    logic [15:0]     sum_q, sum_d;
    localparam state_t AFTER_DATA = CSUM_HI;
`else
    localparam state_t AFTER_DATA = FIN;
`endif

    assign n_hdr    = {1'b0, hi_q, rx_data};
    assign in_frame = state_q inside {HDR_HI, HDR_LO, DATA_HI, DATA_LO, CSUM_HI, CSUM_LO};

    always_comb begin
        state_d     = state_q;
        hi_d        = hi_q;
        idx_d       = idx_q;
        rem_d       = rem_q;
        cnt_d       = cnt_q;
        ram_write_d = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        cpu_hold_d  = cpu_hold_q;
        done_d      = done_q;
        error_d     = error_q;
`ifdef ROM_LOADER_CHECKSUM_EN
        sum_d       = sum_q;
`endif
        if (in_frame) begin
            if (rx_valid)
                cnt_d = '0;
            else if (TIMEOUT > 0)
                cnt_d = cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: if (start) begin
                state_d    = HDR_HI;
                cpu_hold_d = 1'b1;
                done_d     = 1'b0;
                error_d    = 1'b0;
                idx_d      = '0;
                cnt_d      = '0;
`ifdef ROM_LOADER_CHECKSUM_EN
                sum_d      = '0;
`endif
            end
            HDR_HI: if (rx_valid) begin
                hi_d    = rx_data;
                state_d = HDR_LO;
            end
            HDR_LO: if (rx_valid) begin
                rem_d = n_hdr;
                if (n_hdr == 17'd0)
                    state_d = AFTER_DATA;
                else if (n_hdr > DEPTH)
                    state_d = ERR;
                else
                    state_d = DATA_HI;
            end
            DATA_HI: if (rx_valid) begin
                hi_d    = rx_data;
                state_d = DATA_LO;
            end
            DATA_LO: if (rx_valid) begin
                ram_write_d = 1'b1;
                ram_addr_d  = idx_q;
                ram_wdata_d = DW'({hi_q, rx_data});
                idx_d       = idx_q + 1'b1;
                rem_d       = rem_q - 1'b1;
`ifdef ROM_LOADER_CHECKSUM_EN
                sum_d       = sum_q + {hi_q, rx_data};
`endif
                state_d     = (rem_q == 17'd1) ? AFTER_DATA : DATA_HI;
            end
`ifdef ROM_LOADER_CHECKSUM_EN
            CSUM_HI: if (rx_valid) begin
                hi_d    = rx_data;
                state_d = CSUM_LO;
            end
            CSUM_LO: if (rx_valid)
                state_d = ({hi_q, rx_data} == sum_q) ? FIN : ERR;
`endif
            FIN: begin
                done_d     = 1'b1;
                cpu_hold_d = 1'b0;
                state_d    = IDLE;
            end
            ERR: begin
                error_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A byte in the final cycle of the window wins over the timeout.
        if (in_frame && !rx_valid && TIMEOUT > 0 && cnt_q == TO_LAST)
            state_d = ERR;

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            hi_q        <= '0;
            idx_q       <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            ram_write_q <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            cpu_hold_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
`ifdef ROM_LOADER_CHECKSUM_EN
            sum_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            hi_q        <= hi_d;
            idx_q       <= idx_d;
            rem_q       <= rem_d;
            cnt_q       <= cnt_d;
            ram_write_q <= ram_write_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            cpu_hold_q  <= cpu_hold_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
`ifdef ROM_LOADER_CHECKSUM_EN
            sum_q       <= sum_d;
`endif
        end
    end

    assign ram_addr  = ram_addr_q;
    assign ram_write = ram_write_q;
    assign ram_wdata = ram_wdata_q;
    assign cpu_hold  = cpu_hold_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule
